// File: rtl/sc_cfg_pkg.sv
// Shared register map, FSM state type and status layout for the scanconverter
// configuration sequencer.
package sc_cfg_pkg;

    localparam int unsigned NUM_CFG_WORDS = 9;
    localparam int unsigned NUM_OUT_WORDS = 8;

    localparam logic [3:0] REG_HV0    = 4'd0;
    localparam logic [3:0] REG_HV2    = 4'd1;
    localparam logic [3:0] REG_HV3    = 4'd2;
    localparam logic [3:0] REG_XY0    = 4'd3;
    localparam logic [3:0] REG_XY2    = 4'd4;
    localparam logic [3:0] REG_MISC   = 4'd5;
    localparam logic [3:0] REG_SL0    = 4'd6;
    localparam logic [3:0] REG_SL2    = 4'd7;
    localparam logic [3:0] REG_CTRL   = 4'd8;
    localparam logic [3:0] REG_STATUS = 4'd9;

    localparam int unsigned ST_STATE_LSB   = 0;
    localparam int unsigned ST_DIRTY_LSB   = 2;
    localparam int unsigned ST_WR_ERR_BIT  = 11;
    localparam int unsigned ST_TIMEOUT_BIT = 12;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StApply = 2'd2
    } seq_state_e;

    function automatic logic [31:0] pack_status(
        input logic [1:0]               st,
        input logic [NUM_CFG_WORDS-1:0] dirty,
        input logic                     wr_err,
        input logic                     timeout
    );
        logic [31:0] s;
        s = '0;
        s[ST_STATE_LSB +: 2]             = st;
        s[ST_DIRTY_LSB +: NUM_CFG_WORDS] = dirty;
        s[ST_WR_ERR_BIT]                 = wr_err;
        s[ST_TIMEOUT_BIT]                = timeout;
        return s;
    endfunction

endpackage

// File: rtl/sc_edge_timeout.sv
// VSYNC falling-edge detector and ARMED-state timeout counter for the
// configuration sequencer.
module sc_edge_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 4194304,
    parameter int unsigned TO_W           = 23
) (
    input  logic PCLK_OUT_i,
    input  logic reset_i,
    input  logic VSYNC_i,
    input  logic cnt_clr_i,
    input  logic cnt_inc_i,
    output logic edge_o,
    output logic expired_o
);

    localparam logic [TO_W-1:0] TermCount = TO_W'(TIMEOUT_CYCLES - 1);

    logic            vsync_prev_q;
    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            vsync_prev_q <= 1'b1;
        end else begin
            vsync_prev_q <= VSYNC_i;
        end
    end

    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (cnt_inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        edge_o    = vsync_prev_q & ~VSYNC_i;
        // A real VSYNC edge on the terminal count takes precedence over timeout.
        expired_o = (cnt_q == TermCount) & ~edge_o;
    end

endmodule

// File: rtl/sc_config_sequencer.sv
// Shadow/active configuration register file with a commit FSM that applies
// dirty shadow words on the VSYNC falling edge, immediately, or on timeout.
module sc_config_sequencer
    import sc_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4194304,
    parameter int unsigned TO_W           = 23
) (
    input  logic        PCLK_OUT_i,
    input  logic        reset_i,
    input  logic        cpu_wr_i,
    input  logic        cpu_rd_i,
    input  logic [3:0]  cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    input  logic        commit_req_i,
    input  logic        commit_imm_i,
    input  logic        VSYNC_i,
    output logic        busy_o,
    output logic        commit_done_o,
    output logic [31:0] hv_out_config_o,
    output logic [31:0] hv_out_config2_o,
    output logic [31:0] hv_out_config3_o,
    output logic [31:0] xy_out_config_o,
    output logic [31:0] xy_out_config2_o,
    output logic [31:0] misc_config_o,
    output logic [31:0] sl_config_o,
    output logic [31:0] sl_config2_o,
    output logic        testpattern_enable_o
);

    seq_state_e state_q, state_d;

    logic [NUM_OUT_WORDS-1:0][31:0] shadow_q;
    logic [NUM_OUT_WORDS-1:0][31:0] active_q;
    logic                           tp_shadow_q;
    logic                           tp_active_q;
    logic [NUM_CFG_WORDS-1:0]       dirty_q, dirty_d;
    logic                           wr_err_q, wr_err_d;
    logic                           timeout_q, timeout_d;
    logic [31:0]                    rdata_q, rdata_d;
    logic                           commit_done_q;

    logic vsync_fall;
    logic to_expired;
    logic cnt_clr;
    logic cnt_inc;
    logic apply_en;
    logic timeout_set;
    logic wr_ok;
    logic wr_drop;
    logic status_rd;

    sc_edge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_edge_timeout (
        .PCLK_OUT_i (PCLK_OUT_i),
        .reset_i    (reset_i),
        .VSYNC_i    (VSYNC_i),
        .cnt_clr_i  (cnt_clr),
        .cnt_inc_i  (cnt_inc),
        .edge_o     (vsync_fall),
        .expired_o  (to_expired)
    );

    // FSM: state register
    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (commit_req_i) begin
                    state_d = commit_imm_i ? StApply : StArmed;
                end
            end
            StArmed: begin
                if (vsync_fall || to_expired) begin
                    state_d = StApply;
                end
            end
            StApply: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and control strobes
    always_comb begin
        busy_o      = (state_q != StIdle);
        apply_en    = (state_q == StApply);
        cnt_inc     = (state_q == StArmed);
        cnt_clr     = (state_q == StIdle) & commit_req_i & ~commit_imm_i;
        timeout_set = (state_q == StArmed) & to_expired;
    end

    always_comb begin
        wr_ok     = cpu_wr_i & (state_q == StIdle) & (cpu_addr_i <= REG_CTRL);
        wr_drop   = cpu_wr_i & (state_q != StIdle);
        status_rd = cpu_rd_i & (cpu_addr_i == REG_STATUS);
    end

    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            shadow_q    <= '0;
            tp_shadow_q <= 1'b0;
        end else if (wr_ok) begin
            if (cpu_addr_i == REG_CTRL) begin
                tp_shadow_q <= cpu_wdata_i[0];
            end else begin
                shadow_q[cpu_addr_i[2:0]] <= cpu_wdata_i;
            end
        end
    end

    // Only dirty words are copied so clean active words never see a write.
    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            active_q    <= '0;
            tp_active_q <= 1'b0;
        end else if (apply_en) begin
            for (int i = 0; i < int'(NUM_OUT_WORDS); i++) begin
                if (dirty_q[i]) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (dirty_q[REG_CTRL]) begin
                tp_active_q <= tp_shadow_q;
            end
        end
    end

    always_comb begin
        dirty_d = dirty_q;
        if (apply_en) begin
            dirty_d = '0;
        end
        if (wr_ok) begin
            dirty_d[cpu_addr_i] = 1'b1;
        end
    end

    // Status read clears the sticky flags, but a flag raised on the same edge survives.
    always_comb begin
        wr_err_d  = wr_err_q;
        timeout_d = timeout_q;
        if (status_rd) begin
            wr_err_d  = 1'b0;
            timeout_d = 1'b0;
        end
        if (wr_drop) begin
            wr_err_d = 1'b1;
        end
        if (timeout_set) begin
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (cpu_addr_i < REG_CTRL) begin
            rdata_d = shadow_q[cpu_addr_i[2:0]];
        end else if (cpu_addr_i == REG_CTRL) begin
            rdata_d = {31'b0, tp_shadow_q};
        end else if (cpu_addr_i == REG_STATUS) begin
            rdata_d = pack_status(state_q, dirty_q, wr_err_q, timeout_q);
        end
    end

    always_ff @(posedge PCLK_OUT_i) begin
        if (reset_i) begin
            dirty_q       <= '0;
            wr_err_q      <= 1'b0;
            timeout_q     <= 1'b0;
            rdata_q       <= '0;
            commit_done_q <= 1'b0;
        end else begin
            dirty_q       <= dirty_d;
            wr_err_q      <= wr_err_d;
            timeout_q     <= timeout_d;
            commit_done_q <= apply_en;
            if (cpu_rd_i) begin
                rdata_q <= rdata_d;
            end
        end
    end

    always_comb begin
        cpu_rdata_o          = rdata_q;
        commit_done_o        = commit_done_q;
        hv_out_config_o      = active_q[REG_HV0[2:0]];
        hv_out_config2_o     = active_q[REG_HV2[2:0]];
        hv_out_config3_o     = active_q[REG_HV3[2:0]];
        xy_out_config_o      = active_q[REG_XY0[2:0]];
        xy_out_config2_o     = active_q[REG_XY2[2:0]];
        misc_config_o        = active_q[REG_MISC[2:0]];
        sl_config_o          = active_q[REG_SL0[2:0]];
        sl_config2_o         = active_q[REG_SL2[2:0]];
        testpattern_enable_o = tp_active_q;
    end

endmodule

// File: doc/sc_config_sequencer.md
Name: sc_config_sequencer

Overview:
- Owns the run-time configuration words that drive the scanconverter output timing and postprocess pipeline.
- Holds CPU-written shadow copies of those words and commits only the dirty ones to the active outputs at a safe point.
- The safe point is the output VSYNC falling edge, so timing and mask parameters never change mid-frame. Immediate and timeout-forced commits are also supported.
- Sits in the output pixel clock domain, between the CPU register bridge and the scanconverter config inputs.

Parameters:
- TIMEOUT_CYCLES, 4194304: ARMED cycles without a VSYNC edge before a forced commit; must be ≥2.
- TO_W, 23: timeout counter width; must satisfy 2^TO_W ≥ TIMEOUT_CYCLES.

Ports:
- PCLK_OUT_i  in  1  output pixel clock; the block's only clock.
- reset_i  in  1  synchronous, active-high reset.
- cpu_wr_i  in  1  write strobe, one cycle per write.
- cpu_rd_i  in  1  read strobe, one cycle per read.
- cpu_addr_i  in  4  register index.
- cpu_wdata_i  in  32  write data.
- cpu_rdata_o  out  32  registered read data.
- commit_req_i  in  1  commit request pulse.
- commit_imm_i  in  1  qualifies commit_req_i: skip waiting for VSYNC.
- VSYNC_i  in  1  scanconverter VSYNC_o, active-low.
- busy_o  out  1  high while the FSM is not IDLE.
- commit_done_o  out  1  one-cycle pulse when the active outputs update.
- hv_out_config_o, hv_out_config2_o, hv_out_config3_o, xy_out_config_o, xy_out_config2_o, misc_config_o, sl_config_o, sl_config2_o  out  32 each  active config words.
- testpattern_enable_o  out  1  active test pattern enable.

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - FSM goes to IDLE.
  - All shadow and active registers clear to 0; testpattern_enable_o=0.
  - dirty[8:0], wr_err and timeout flags clear; the timeout counter clears; vsync_prev is set to 1.
  - cpu_rdata_o=0, busy_o=0, commit_done_o=0.
  - Reset mid-commit abandons the commit; no commit_done_o pulse follows.
- Register map:
  - 0..7: the eight config words, in port-list order.
  - 8: control; bit0 is testpattern enable, bits [31:1] read 0.
  - 9: status, read-only: [1:0]=state, [10:2]=dirty, [11]=wr_err, [12]=timeout, others 0.
  - 10..15: writes ignored, reads return 0.
- Writes:
  - In IDLE, a write to 0..8 updates the shadow word and sets dirty[addr] in the same edge.
  - In any other state the write is dropped and wr_err is set (sticky).
- Reads: cpu_rdata_o is valid 1 cycle after cpu_rd_i. Reading address 9 clears wr_err and timeout on that edge. A flag set on the same edge wins over the clear.
- FSM encoding: IDLE=0, ARMED=1, APPLY=2.
  - IDLE→APPLY when commit_req_i & commit_imm_i.
  - IDLE→ARMED when commit_req_i & ~commit_imm_i; the timeout counter clears to 0.
  - ARMED→APPLY on a VSYNC falling edge (vsync_prev=1 & VSYNC_i=0). vsync_prev updates every cycle in every state.
  - ARMED→APPLY with timeout set when the counter == TIMEOUT_CYCLES-1 and no edge occurs that cycle. If an edge and the terminal count coincide, the edge wins and timeout is not set.
  - Otherwise ARMED stays, and the counter increments.
  - APPLY→IDLE always. On this edge every word with dirty=1 is copied shadow→active, dirty clears to 0, and commit_done_o=1 for exactly the next cycle.
  - commit_req_i outside IDLE is ignored.
- Latency:
  - Immediate commit: commit_req_i at cycle N → new active values and commit_done_o at N+2.
  - Synchronized commit: edge sampled at cycle M → active values and commit_done_o at M+2.
- Clean words are never rewritten. A commit with dirty=0 still runs the full sequence and pulses commit_done_o with the outputs unchanged.
- busy_o=1 exactly when the FSM is in ARMED or APPLY.

Decomposition:
- Package sc_cfg_pkg: register index localparams (REG_HV0..REG_CTRL=8, REG_STATUS=9), state enum, NUM_CFG_WORDS=9, status bit positions.
- Sub-module sc_edge_timeout holds vsync_prev, the falling-edge detect and the timeout counter. Outputs: edge, expired.
- The register file and FSM remain in the top module.

Test Plan:
- Reset, then read 0..9 → all 0. Outputs 0, busy_o=0.
- Write reg0=0x12345678 in IDLE; commit with imm=1 at cycle N → hv_out_config_o=0x12345678 and commit_done_o=1 at N+2. Other outputs stay 0; status dirty=0.
- Write reg5=0xA5; request a commit with imm=0 while VSYNC_i=1, then drive VSYNC_i 1→0 at cycle M → misc_config_o=0xA5 exactly at M+2 and not before. busy_o=1 from request+1 through M+1.
- Write reg3 while ARMED → value dropped, status bit11=1. A second status read returns bit11=0.
- TIMEOUT_CYCLES=16, VSYNC_i held 1, commit with imm=0 → outputs update 18 cycles after the request, status bit12=1. Repeat with the VSYNC edge on the terminal-count cycle → commit completes at the same point, bit12=0.
- Assert reset_i in ARMED with dirty=0x001 → no commit_done_o pulse, active and shadow registers 0, state IDLE.
